log_batch_seq: RTL

- Sequencer for the float32 natural-log core used in the MFCC path.
- Streams a batch of `len` float32 words from a source SRAM read port into the log core's valid-only AXI-stream input, and collects results into a destination SRAM write port.
- Sits between the log register/AHB front-end, which supplies start/base/len and sees busy/done/err, and the log core.
- The log core has no backpressure, so the block issues one word per cycle and sinks every result on arrival.

---
 rtl/log_seq_pkg.sv | 16 +
 rtl/log_batch_seq_if.sv | 30 +++
 rtl/log_batch_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/log_seq_pkg.sv
// Shared definitions for the log batch sequencer.
//   seq_state_t : sequencer FSM states
//   MAX_LEN     : largest batch accepted at start
package log_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH,
        DONE
    } seq_state_t;

    localparam int MAX_LEN = 256;

endpackage

// File: rtl/log_batch_seq_if.sv
// Datapath bundle between the log batch sequencer, the source/destination
// SRAM ports and the float32 log core.
//   master : sequencer side (drives reads, core input, writes)
//   slave  : memory/core side
interface log_batch_seq_if #(
    parameter int ADDR_W = 8
);
    logic              src_rd_en;
    logic [ADDR_W-1:0] src_addr;
    logic [31:0]       src_rdata;
    logic              ln_a_valid;
    logic [31:0]       ln_a_data;
    logic              ln_res_valid;
    logic [31:0]       ln_res_data;
    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_addr;
    logic [31:0]       dst_wdata;

    modport master (
        output src_rd_en, src_addr, ln_a_valid, ln_a_data,
               dst_wr_en, dst_addr, dst_wdata,
        input  src_rdata, ln_res_valid, ln_res_data
    );

    modport slave (
        input  src_rd_en, src_addr, ln_a_valid, ln_a_data,
               dst_wr_en, dst_addr, dst_wdata,
        output src_rdata, ln_res_valid, ln_res_data
    );
endinterface

// File: rtl/log_batch_seq.sv
// Batch sequencer for the float32 natural-log core (MFCC path).
// Streams len words from the source SRAM into the log core, one per cycle,
// and writes every result to the destination SRAM as it arrives.
//   hclk, rst_n                 : clock, asynchronous active-low reset
//   start, abort                : one-cycle control pulses
//   src_base, dst_base, len     : batch configuration, captured on start
//   busy, done, err             : status (err is sticky until reset)
//   bus                         : SRAM read/write ports and log core stream
module log_batch_seq
    import log_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9,
    parameter int OUT_W  = 6
) (
    input  logic               hclk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  src_base,
    input  logic [ADDR_W-1:0]  dst_base,
    input  logic [CNT_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               err,
    log_batch_seq_if.master    bus
);

    seq_state_t        state_reg;
    logic [ADDR_W-1:0] src_base_reg;
    logic [ADDR_W-1:0] dst_base_reg;
    logic [ADDR_W-1:0] src_addr_reg;
    logic [ADDR_W-1:0] dst_addr_reg;
    logic [CNT_W-1:0]  len_reg;
    logic [CNT_W-1:0]  rd_cnt_reg;
    logic [CNT_W-1:0]  wr_cnt_reg;
    logic [OUT_W-1:0]  outstanding_reg;
    logic [OUT_W-1:0]  outstanding_next;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              src_rd_en_reg;
    logic              ln_a_valid_reg;
    logic              dst_wr_en_reg;
    logic [31:0]       dst_wdata_reg;

    logic res_stray;   // result with nothing in flight: flagged, never written
    logic res_ok;      // result that belongs to an issued word
    logic res_take;    // result that is actually written to the destination

    assign res_stray = bus.ln_res_valid && (outstanding_reg == '0);
    assign res_ok    = bus.ln_res_valid && !res_stray;
    // Results seen while flushing (or in the abort cycle itself) are dropped.
    assign res_take  = res_ok && !abort &&
                       ((state_reg == ISSUE) || (state_reg == DRAIN));

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign err            = err_reg;
    assign bus.src_rd_en  = src_rd_en_reg;
    assign bus.src_addr   = src_addr_reg;
    assign bus.ln_a_valid = ln_a_valid_reg;
    assign bus.ln_a_data  = bus.src_rdata;   // SRAM data lines up with the delayed strobe
    assign bus.dst_wr_en  = dst_wr_en_reg;
    assign bus.dst_addr   = dst_addr_reg;
    assign bus.dst_wdata  = dst_wdata_reg;

    // Words inside the core: entering and leaving in one cycle cancels out.
    always_comb begin
        outstanding_next = outstanding_reg;
        if (ln_a_valid_reg && !res_ok) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!ln_a_valid_reg && res_ok) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            src_base_reg    <= '0;
            dst_base_reg    <= '0;
            src_addr_reg    <= '0;
            dst_addr_reg    <= '0;
            len_reg         <= '0;
            rd_cnt_reg      <= '0;
            wr_cnt_reg      <= '0;
            outstanding_reg <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            src_rd_en_reg   <= 1'b0;
            ln_a_valid_reg  <= 1'b0;
            dst_wr_en_reg   <= 1'b0;
            dst_wdata_reg   <= '0;
        end else begin
            done_reg        <= 1'b0;
            dst_wr_en_reg   <= 1'b0;
            ln_a_valid_reg  <= src_rd_en_reg;
            outstanding_reg <= outstanding_next;

            if (res_stray) begin
                err_reg <= 1'b1;
            end

            if (res_take) begin
                dst_wr_en_reg <= 1'b1;
                dst_wdata_reg <= bus.ln_res_data;
                dst_addr_reg  <= dst_base_reg + wr_cnt_reg[ADDR_W-1:0];
                wr_cnt_reg    <= wr_cnt_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    // abort in the same cycle swallows the start
                    if (start && !abort) begin
                        if (len > CNT_W'(MAX_LEN)) begin
                            err_reg <= 1'b1;
                        end else begin
                            src_base_reg <= src_base;
                            dst_base_reg <= dst_base;
                            len_reg      <= len;
                            wr_cnt_reg   <= '0;
                            if (len == '0) begin
                                state_reg  <= DONE;
                                done_reg   <= 1'b1;
                                rd_cnt_reg <= '0;
                            end else begin
                                // first read goes out in the very next cycle
                                state_reg     <= ISSUE;
                                busy_reg      <= 1'b1;
                                src_rd_en_reg <= 1'b1;
                                src_addr_reg  <= src_base;
                                rd_cnt_reg    <= CNT_W'(1);
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        src_rd_en_reg <= 1'b0;
                        state_reg     <= FLUSH;
                    end else if (rd_cnt_reg == len_reg) begin
                        src_rd_en_reg <= 1'b0;
                        state_reg     <= DRAIN;
                    end else begin
                        src_addr_reg <= src_base_reg + rd_cnt_reg[ADDR_W-1:0];
                        rd_cnt_reg   <= rd_cnt_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_reg <= FLUSH;
                    end else if ((wr_cnt_reg == len_reg) && !bus.ln_res_valid) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                FLUSH: begin
                    // wait until nothing is left in the SRAM read or the core
                    if ((outstanding_reg == '0) && !ln_a_valid_reg && !src_rd_en_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
